// File: rtl/xclk_word_arbiter.sv
// Shares one DW-bit crossing register among N_REQ requesters; round-robin, or fixed priority (lowest index) with XARB_FIXED_PRIO_EN.
// Latency: grant, word, tag and toggle all register on the edge that sees req in IDLE; word then held HOLD_CYCLES+1 clocks minimum.
// Backpressure: requesters hold req/req_data until their one-cycle gnt; req is ignored while busy.
module xclk_word_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DW          = 12,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic [DW-1:0]            data_out,
  output logic [$clog2(N_REQ)-1:0] tag_out,
  output logic                     valid_tgl,
  output logic                     busy
);

  localparam int TW = $clog2(N_REQ);
  localparam int CW = 8;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [DW-1:0]     data_q, data_d;
  logic [TW-1:0]     tag_q, tag_d;
  logic              tgl_q, tgl_d;
  logic              busy_q, busy_d;

  logic              win_vld;
  logic [TW-1:0]     win_idx;

`ifdef XARB_FIXED_PRIO_EN
  // Descending scan so the lowest asserted index is the last (winning) assignment.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win_idx = TW'(i);
      end
    end
  end
`else
  logic [TW-1:0] ptr_q, ptr_d;
  logic [TW:0]   scan_sum;
  logic [TW-1:0] scan_idx;

  // Scan offsets from N_REQ-1 down to 0 so the request closest to ptr wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_sum = {1'b0, ptr_q} + (TW+1)'(i);
      if (scan_sum >= (TW+1)'(N_REQ)) begin
        scan_sum = scan_sum - (TW+1)'(N_REQ);
      end
      scan_idx = scan_sum[TW-1:0];
      if (req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && win_vld) begin
      ptr_d = (win_idx == TW'(N_REQ - 1)) ? '0 : win_idx + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    data_d  = data_q;
    tag_d   = tag_q;
    tgl_d   = tgl_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYCLES - 1);
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          data_d  = req_data[win_idx*DW +: DW];
          tag_d   = win_idx;
          tgl_d   = ~tgl_q;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      tgl_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      tgl_q   <= tgl_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign data_out  = data_q;
  assign tag_out   = tag_q;
  assign valid_tgl = tgl_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_xclk_word_arbiter.sv
// Randomized and directed bench for xclk_word_arbiter against an edge-count reference model.
module tb_xclk_word_arbiter;

  localparam int N    = 4;
  localparam int DW   = 12;
  localparam int HOLD = 4;
  localparam int TW   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      gnt;
  logic [DW-1:0]     data_out;
  logic [TW-1:0]     tag_out;
  logic              valid_tgl;
  logic              busy;

  xclk_word_arbiter #(.N_REQ(N), .DW(DW), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .data_out(data_out), .tag_out(tag_out),
    .valid_tgl(valid_tgl), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Requester-side stimulus state
  logic [N-1:0]  r = '0;
  logic [DW-1:0] w [N];

  // Reference model: n = rising edges since reset release, g = edge of last grant
  int            n, g, ptr, m_tag;
  logic [N-1:0]  m_gnt;
  logic [DW-1:0] m_data;
  logic          m_tgl, m_busy;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0; g = -1000; ptr = 0; m_tag = 0;
    m_gnt = '0; m_data = '0; m_tgl = 1'b0; m_busy = 1'b0;
  endtask

  function automatic int pick(input logic [N-1:0] rv, input int p);
    int start;
`ifdef XARB_FIXED_PRIO_EN
    start = 0;
`else
    start = p;
`endif
    for (int i = 0; i < N; i++) begin
      if (rv[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  task automatic predict();
    int win;
    m_gnt = '0;
    if ((n - g) >= HOLD && r != '0) begin
      win    = pick(r, ptr);
      g      = n + 1;
      m_gnt[win] = 1'b1;
      m_data = w[win];
      m_tag  = win;
      m_tgl  = ~m_tgl;
      ptr    = (win + 1) % N;
    end
    m_busy = ((n + 1) - g) < HOLD;
    n++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = w[i];
    req = r;
  endtask

  task automatic check_outputs();
    check_eq("gnt",       32'(gnt),       32'(m_gnt));
    check_eq("data_out",  32'(data_out),  32'(m_data));
    check_eq("tag_out",   32'(tag_out),   32'(m_tag));
    check_eq("valid_tgl", 32'(valid_tgl), 32'(m_tgl));
    check_eq("busy",      32'(busy),      32'(m_busy));
  endtask

  // Drive for the next edge, predict it, then sample at the following falling edge.
  task automatic step(input bit keep_on_gnt);
    drive();
    predict();
    @(negedge clk);
    check_outputs();
    if (!keep_on_gnt) r = r & ~m_gnt;
  endtask

  initial begin
    for (int i = 0; i < N; i++) w[i] = '0;
    model_reset();

    // Reset values
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    step(0);

    // Single requester, then a second word interrupted by async reset mid-HOLD
    r[0] = 1'b1; w[0] = 12'hF00;
    repeat (8) step(0);
    r[0] = 1'b1; w[0] = 12'hABC;
    repeat (3) step(0);
    check_eq("pre_reset_data", 32'(data_out), 32'h0000_0ABC);
    rst_n = 1'b0;
    #1;
    check_eq("arst_gnt",  32'(gnt),       32'h0);
    check_eq("arst_data", 32'(data_out),  32'h0);
    check_eq("arst_tag",  32'(tag_out),   32'h0);
    check_eq("arst_tgl",  32'(valid_tgl), 32'h0);
    check_eq("arst_busy", 32'(busy),      32'h0);
    r = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) step(0);

    // All four held: round-robin sequence
    r = 4'b1111;
    w[0] = 12'h111; w[1] = 12'h222; w[2] = 12'h333; w[3] = 12'h444;
    repeat (26) step(1);
    r = '0;
    repeat (6) step(0);

    // Withdrawal during another requester's HOLD
    r[0] = 1'b1; w[0] = 12'h5A5;
    step(0);
    r[2] = 1'b1; w[2] = 12'h777;
    repeat (2) step(0);
    r[2] = 1'b0;
    repeat (5) step(0);
    check_eq("withdraw_data", 32'(data_out), 32'h0000_05A5);

    // Wrap-around: grant 2, then 3 and 0 together
    r[2] = 1'b1; w[2] = 12'h2C2;
    repeat (6) step(0);
    r = 4'b1001; w[0] = 12'h0A0; w[3] = 12'h3D3;
    repeat (12) step(0);

    // Two requesters held continuously
    r = 4'b0110; w[1] = 12'h1E1; w[2] = 12'h2F2;
    repeat (20) step(1);
    r = '0;
    repeat (6) step(0);

    // Random traffic with withdrawals and back-to-back re-requests
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_gnt[i]) begin
          if ($urandom_range(1, 0) == 0) r[i] = 1'b0;
          else w[i] = DW'($urandom);
        end else if (!r[i]) begin
          if ($urandom_range(3, 0) == 0) begin
            r[i] = 1'b1;
            w[i] = DW'($urandom);
          end
        end else if ($urandom_range(19, 0) == 0) begin
          r[i] = 1'b0;
        end
      end
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
